bcd_counter_scan: RTL and testbench
===================================

# bcd_counter_scan

Parametrised multi-digit BCD counter with a time-multiplexed seven-segment driver. Replaces the single-digit 0–9 board counter with:
- a DIGITS-wide decimal count, counting up or down;
- a synchronous parallel load;
- a wrap pulse;
- an anode scan that drives all digits of a common-anode display from one shared segment bus.

It sits between the clock divisor, which supplies `clock_out`, and the board display pins.

## Interface
Parameters:
- DIGITS, 4 — number of BCD digits and anodes; legal range 1–8.
- SCAN_DIV, 4 — `clock_out` cycles per displayed digit; must be ≥1.
- BLANK_LZ, 1 — 1 blanks leading zero digits. Digit 0 is never blanked.

Ports:
- clock_out  in  1  count/scan clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable, sampled each cycle.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe; has priority over en.
- load_val  in  4*DIGITS  BCD load value; digit 0 is in bits [3:0].
- count  out  4*DIGITS  registered BCD count value.
- wrap  out  1  one-cycle pulse on modulo wrap.
- seg  out  7  active-low segments, ordered {g,f,e,d,c,b,a}.
- control  out  DIGITS  active-low anode enables; exactly one bit is low.

## Operation
- **Modulus:** the count range is 0 to 10^DIGITS−1. Each digit holds 0–9 at all times.
- **Priority per cycle:** rst > load > en > hold.
- **load:** count ← load_val. Any load digit greater than 9 is stored as 0. wrap is 0 on a load cycle.
- **en with up=1:** digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. If all digits are 9, the count becomes all 0 and wrap=1.
- **en with up=0:** digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit. If all digits are 0, the count becomes all 9 and wrap=1.
- **en=0 and load=0:** count holds and wrap=0.
- **Scan prescaler:**
  - Counts 0 to SCAN_DIV−1 every cycle and is independent of en and load.
  - At SCAN_DIV−1 it returns to 0 and the digit index advances: 0 → 1 → … → DIGITS−1 → 0.
- **control:** bit[idx] = 0; all other bits = 1.
- **seg:** the decode of count digit[idx]. The encoding is fixed as:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0011000
- **Leading-zero blanking:** when BLANK_LZ=1, idx>0, and digit[idx] and every higher digit are 0, seg = 1111111.
- **Reset values:**
  - count = 0, wrap = 0, prescaler = 0, idx = 0.
  - control = all 1 except bit 0 = 0.
  - seg = 1000000.

## Timing
- count and wrap update on the same edge that samples en, load and up. Latency is 1 cycle.
- seg and control are registered together from the current idx and count. They therefore lag idx and count changes by 1 cycle and are never inconsistent with each other.
- With no reset, the anode changes every SCAN_DIV cycles. A full refresh takes DIGITS×SCAN_DIV cycles. SCAN_DIV=1 scans one digit per cycle.
- load and en asserted together: load wins, and en is ignored for that cycle.
- A direction change takes effect on the next enabled edge and needs no dead cycle.
- rst asserted mid-scan or mid-count: all outputs take their reset values immediately, without waiting for a clock edge. Counting resumes on the first edge after rst deasserts.
- DIGITS=1: control is a constant 0 after reset and leading-zero blanking never applies.

## Structure
- The shared package `seg7_pkg` holds:
  - segment constants SEG_0 to SEG_9 and SEG_BLANK;
  - function `bcd_to_seg(logic [3:0]) → logic [6:0]`; non-BCD inputs return SEG_BLANK.
- Sub-module `bcd_digit`, instantiated DIGITS times in a carry/borrow chain:
  - inputs: clock_out, rst, inc, dec, load, d[3:0];
  - outputs: q[3:0], carry_out (q=9 and inc), borrow_out (q=0 and dec).
- wrap = en & ~load & carry/borrow out of the top digit, registered.

## Test plan
- **Reset value check** (DIGITS=4, SCAN_DIV=2): assert rst mid-run → count=0000, control=1110, seg=1000000 with no clock edge.
- **Up-count wrap:** load 9998, then en=1, up=1 for 2 cycles → count=9999, then 0000; wrap=1 only on the cycle the count becomes 0000.
- **Down-count wrap:** load 0001, then en=1, up=0 for 2 cycles → count=0000, then 9999 with wrap=1. Also check 0100 → 0099 (borrow chain).
- **Load priority and invalid digits:** load=1 and en=1 with load_val=0x12F4 → count=0x1204, wrap=0.
- **Scan and leading-zero blanking** (BLANK_LZ=1, count=0042, SCAN_DIV=3):
  - control sequence 1110, 1101, 1011, 0111, with each value held for 3 cycles;
  - seg sequence 0010010 ("2"), 0011001 ("4"), 1111111, 1111111.
- **Hold:** en=0 for 20 cycles with count=0567 → count unchanged, wrap stays 0, scan continues.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the board display.
// Segments are active-low, ordered {g,f,e,d,c,b,a}.
//   SEG_0..SEG_9 : glyphs for decimal digits
//   SEG_BLANK    : all segments off
//   bcd_to_seg() : BCD digit to segment pattern; non-BCD codes give SEG_BLANK
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter chain.
// Ports:
//   clock_out  : count clock (rising edge)
//   rst        : asynchronous active-high reset, clears q
//   inc / dec  : step this digit up / down (from the lower digit's carry/borrow)
//   load, d    : synchronous load; codes above 9 are stored as 0
//   q          : current digit value, always 0..9
//   carry_out  : q == 9 while incrementing
//   borrow_out : q == 0 while decrementing
module bcd_digit (
    input  logic       clock_out,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] d,
    output logic [3:0] q,
    output logic       carry_out,
    output logic       borrow_out
);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = (d > 4'd9) ? 4'd0 : d;
        end else if (inc) begin
            q_d = (q_q == 4'd9) ? 4'd0 : q_q + 4'd1;
        end else if (dec) begin
            q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
        end
    end

    always_ff @(posedge clock_out or posedge rst) begin
        if (rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q          = q_q;
    assign carry_out  = inc & (q_q == 4'd9);
    assign borrow_out = dec & (q_q == 4'd0);

endmodule

// File: rtl/bcd_counter_scan.sv
// Multi-digit up/down BCD counter with a multiplexed common-anode display driver.
// Ports:
//   clock_out : count/scan clock (rising edge)
//   rst       : asynchronous active-high reset
//   en, up    : count enable and direction (1 = up)
//   load      : synchronous load of load_val, overrides en
//   load_val  : BCD load value, digit 0 in [3:0]
//   count     : registered BCD count
//   wrap      : one-cycle pulse when the count wraps modulo 10^DIGITS
//   seg       : active-low segments {g,f,e,d,c,b,a} of the scanned digit
//   control   : active-low anode enables, one bit low
module bcd_counter_scan
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  clock_out,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  wrap,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     control
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

    // Carry/borrow ripple: entry [g] steps digit g, entry [DIGITS] leaves the top digit.
    logic [DIGITS:0] inc_chain;
    logic [DIGITS:0] dec_chain;

    assign inc_chain[0] = en & up & ~load;
    assign dec_chain[0] = en & ~up & ~load;

    for (genvar g = 0; g < DIGITS; g++) begin : gen_digit
        bcd_digit u_digit (
            .clock_out  (clock_out),
            .rst        (rst),
            .inc        (inc_chain[g]),
            .dec        (dec_chain[g]),
            .load       (load),
            .d          (load_val[4*g +: 4]),
            .q          (count[4*g +: 4]),
            .carry_out  (inc_chain[g+1]),
            .borrow_out (dec_chain[g+1])
        );
    end

    logic              wrap_q, wrap_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] control_q, control_d;
    logic [3:0]        digit_sel;
    logic              upper_nz;

    // Chain entries are already gated by en & ~load, so the top carry/borrow is the wrap.
    assign wrap_d = inc_chain[DIGITS] | dec_chain[DIGITS];

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end
    end

    // Display registers sample the current idx/count so seg and control move together.
    always_comb begin
        digit_sel = 4'd0;
        upper_nz  = 1'b0;
        control_d = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IW'(i) == idx_q) begin
                digit_sel    = count[4*i +: 4];
                control_d[i] = 1'b0;
            end
            if ((i >= int'(idx_q)) && (count[4*i +: 4] != 4'd0)) begin
                upper_nz = 1'b1;
            end
        end
        seg_d = bcd_to_seg(digit_sel);
        if ((BLANK_LZ != 0) && (idx_q != '0) && !upper_nz) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clock_out or posedge rst) begin
        if (rst) begin
            wrap_q    <= 1'b0;
            presc_q   <= '0;
            idx_q     <= '0;
            seg_q     <= SEG_0;
            control_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            wrap_q    <= wrap_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            control_q <= control_d;
        end
    end

    assign wrap    = wrap_q;
    assign seg     = seg_q;
    assign control = control_q;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Self-checking bench for bcd_counter_scan (DIGITS=4, SCAN_DIV=3, BLANK_LZ=1).
// Reference model keeps the count as an integer modulo 10^DIGITS and derives the
// scanned digit from the number of edges since reset.
module tb_bcd_counter_scan;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 3;
    localparam int unsigned BLANK_LZ = 1;
    localparam int unsigned MOD      = 10000;

    logic        clock_out;
    logic        rst;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] count;
    logic        wrap;
    logic [6:0]  seg;
    logic [3:0]  control;

    bcd_counter_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (BLANK_LZ)
    ) dut (
        .clock_out (clock_out),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .wrap      (wrap),
        .seg       (seg),
        .control   (control)
    );

    initial begin
        clock_out = 1'b0;
        forever #5 clock_out = ~clock_out;
    end

    int unsigned total;
    int unsigned passed;

    // Reference state
    int unsigned cnt_m;
    int unsigned t_m;
    logic        wrap_m;
    logic [6:0]  seg_m;
    logic [3:0]  ctrl_m;
    logic [6:0]  seg_tab [10];

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r = 1;
        for (int i = 0; i < int'(n); i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int unsigned load_value(input logic [15:0] lv);
        int unsigned v = 0;
        for (int i = 0; i < 4; i++) begin
            if (lv[4*i +: 4] <= 4'd9) v = v + int'(lv[4*i +: 4]) * pow10(i);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        cnt_m  = 0;
        t_m    = 0;
        wrap_m = 1'b0;
        seg_m  = seg_tab[0];
        ctrl_m = 4'b1110;
    endtask

    // One clock edge: model the edge, then compare all outputs just after it.
    task automatic step();
        int unsigned idx;
        int unsigned upper;
        @(posedge clock_out);
        idx   = (t_m / SCAN_DIV) % DIGITS;
        upper = cnt_m / pow10(idx);
        if (BLANK_LZ != 0 && idx > 0 && upper == 0) seg_m = 7'b1111111;
        else seg_m = seg_tab[upper % 10];
        ctrl_m = ~(4'b0001 << idx);
        if (load) begin
            cnt_m  = load_value(load_val);
            wrap_m = 1'b0;
        end else if (en && up) begin
            wrap_m = (cnt_m == MOD - 1);
            cnt_m  = (cnt_m + 1) % MOD;
        end else if (en) begin
            wrap_m = (cnt_m == 0);
            cnt_m  = (cnt_m + MOD - 1) % MOD;
        end else begin
            wrap_m = 1'b0;
        end
        t_m++;
        #1;
        chk("count", 32'(count), 32'(to_bcd(cnt_m)));
        chk("wrap", 32'(wrap), 32'(wrap_m));
        chk("seg", 32'(seg), 32'(seg_m));
        chk("control", 32'(control), 32'(ctrl_m));
    endtask

    // Asynchronous reset asserted away from the clock edge, checked before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_wrap"}, 32'(wrap), 32'h0);
        chk({tag, "_seg"}, 32'(seg), 32'(7'b1000000));
        chk({tag, "_control"}, 32'(control), 32'(4'b1110));
        model_reset();
        @(negedge clock_out);
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        load     = 1'b1;
        load_val = v;
        step();
        load     = 1'b0;
    endtask

    initial begin
        int unsigned r;
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0011000;
        total = 0; passed = 0;
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0;
        model_reset();
        @(posedge clock_out);
        #1;
        async_reset("por");

        // Run a little, then reset mid-count/mid-scan.
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 7; i++) step();
        async_reset("mid_rst");

        // Up wrap
        en = 1'b0;
        do_load(16'h9998);
        en = 1'b1; up = 1'b1;
        step();
        chk("up_9999", 32'(count), 32'h9999);
        chk("up_9999_wrap", 32'(wrap), 32'h0);
        step();
        chk("up_wrap_count", 32'(count), 32'h0000);
        chk("up_wrap_pulse", 32'(wrap), 32'h1);
        step();
        chk("up_after_wrap", 32'(wrap), 32'h0);

        // Down wrap and borrow chain
        en = 1'b0;
        do_load(16'h0001);
        en = 1'b1; up = 1'b0;
        step();
        chk("dn_0000", 32'(count), 32'h0000);
        step();
        chk("dn_wrap_count", 32'(count), 32'h9999);
        chk("dn_wrap_pulse", 32'(wrap), 32'h1);
        en = 1'b0;
        do_load(16'h0100);
        en = 1'b1;
        step();
        chk("dn_borrow", 32'(count), 32'h0099);

        // Load priority with an invalid digit
        en = 1'b1; up = 1'b1;
        do_load(16'h12F4);
        chk("load_prio", 32'(count), 32'h1204);
        chk("load_wrap", 32'(wrap), 32'h0);

        // Scan with blanking from a fresh phase
        async_reset("scan_rst");
        en = 1'b0;
        do_load(16'h0042);
        for (int i = 0; i < 2 * int'(DIGITS * SCAN_DIV); i++) step();

        // Hold
        do_load(16'h0567);
        en = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("hold_count", 32'(count), 32'h0567);

        // Randomized traffic, biased toward the wrap boundaries
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset("rand_rst");
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) == 1;
            load = ($urandom_range(0, 7) == 0);
            r    = $urandom_range(0, 3);
            if (r == 0) load_val = to_bcd(9995 + $urandom_range(0, 4));
            else if (r == 1) load_val = to_bcd($urandom_range(0, 4));
            else load_val = 16'($urandom);
            step();
        end
        load = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
